// File: rtl/alu_pkg.sv
// Shared types and constants for the pipelined ALU: op codes, FSM states and
// op-code width.
package alu_pkg;

    localparam int unsigned OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OpAnd  = 4'd0,
        OpOr   = 4'd1,
        OpAdd  = 4'd2,
        OpSub  = 4'd3,
        OpAddc = 4'd4,
        OpSlt  = 4'd5,
        OpSltu = 4'd6,
        OpNor  = 4'd7,
        OpXor  = 4'd8,
        OpSll  = 4'd9,
        OpSrl  = 4'd10,
        OpSra  = 4'd11,
        OpMul  = 4'd12,
        OpRsv0 = 4'd13,
        OpRsv1 = 4'd14,
        OpRsv2 = 4'd15
    } op_e;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StMul  = 1'b1
    } state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath for every single-cycle op. MUL and the reserved
// codes fall through to an all-zero result with clear flags.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned SHW = $clog2(WIDTH);

    op_e              op_dec;
    logic             is_sub;
    logic             carry_in;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic             add_ovf;
    logic             lt_signed;
    logic             lt_unsigned;
    logic [SHW-1:0]   shamt;

    assign op_dec = op_e'(op);
    assign is_sub = (op_dec == OpSub);

    // One shared adder serves ADD, ADDC and SUB; SUB is a + ~b + 1.
    assign b_eff    = is_sub ? ~b : b;
    assign carry_in = is_sub ? 1'b1 : ((op_dec == OpAddc) ? cin : 1'b0);
    assign sum      = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, carry_in};
    assign add_ovf  = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

    assign lt_signed   = ($signed(a) < $signed(b));
    assign lt_unsigned = (a < b);
    assign shamt       = b[SHW-1:0];

    always_comb begin
        result = '0;
        cout   = 1'b0;
        ovf    = 1'b0;
        case (op_dec)
            OpAnd:  result = a & b;
            OpOr:   result = a | b;
            OpNor:  result = ~(a | b);
            OpXor:  result = a ^ b;
            OpAdd, OpSub, OpAddc: begin
                result = sum[WIDTH-1:0];
                cout   = sum[WIDTH];
                ovf    = add_ovf;
            end
            OpSlt:  result = {{(WIDTH-1){1'b0}}, lt_signed};
            OpSltu: result = {{(WIDTH-1){1'b0}}, lt_unsigned};
            OpSll:  result = a << shamt;
            OpSrl:  result = a >> shamt;
            OpSra:  result = WIDTH'($signed(a) >>> shamt);
            default: begin
                result = '0;
                cout   = 1'b0;
                ovf    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes on both sides and a multi-cycle
// shift-add multiplier that stalls input acceptance while it runs.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero,
    output logic             ovf
);

    localparam int unsigned    SHW      = $clog2(WIDTH);
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]   cnt_q, cnt_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] core_result;
    logic             core_cout;
    logic             core_ovf;
    logic [WIDTH-1:0] acc_step;
    logic             accept;
    logic             xfer;
    logic             is_mul;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op     (op),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .result (core_result),
        .cout   (core_cout),
        .ovf    (core_ovf)
    );

    assign in_ready = rst_n && (state_q == StIdle) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign xfer     = out_valid_q && out_ready;
    assign is_mul   = (op_e'(op) == OpMul);
    assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        cout_d      = cout_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;

        if (xfer) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (is_mul) begin
                        mcand_d  = a;
                        mplier_d = b;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = StMul;
                    end else begin
                        result_d    = core_result;
                        cout_d      = core_cout;
                        ovf_d       = core_ovf;
                        zero_d      = (core_result == '0);
                        out_valid_d = 1'b1;
                    end
                end
            end
            StMul: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                // Output register is guaranteed free here: accept required it.
                if (cnt_q == CNT_LAST) begin
                    result_d    = acc_step;
                    cout_d      = 1'b0;
                    ovf_d       = 1'b0;
                    zero_d      = (acc_step == '0);
                    out_valid_d = 1'b1;
                    state_d     = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            cout_q      <= 1'b0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            cout_q      <= cout_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign cout      = cout_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;

`ifndef SYNTHESIS
    a_mul_blocks_input : assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == StMul) |-> !in_ready);
    a_hold_stable : assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid_q && !out_ready) |=> (out_valid_q && $stable(result_q)
                                         && $stable({cout_q, zero_q, ovf_q})));
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe at WIDTH = 32: expectations from a behavioural
// model are queued on accept and compared as results leave the output port.
module tb_alu_pipe;

    localparam int unsigned WIDTH = 32;

    typedef struct packed {
        logic [31:0] r;
        logic        c;
        logic        z;
        logic        v;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        cout;
    logic        zero;
    logic        ovf;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_out    = 0;

    alu_pipe #(
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .zero      (zero),
        .ovf       (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [3:0] o, input logic [31:0] x,
                                   input logic [31:0] y, input logic c);
        exp_t        e;
        longint      s;
        logic [63:0] p;
        logic [32:0] u;
        e = '0;
        s = 0;
        case (o)
            4'd0: e.r = x & y;
            4'd1: e.r = x | y;
            4'd2, 4'd4: begin
                u   = {1'b0, x} + {1'b0, y} + ((o == 4'd4) ? {32'd0, c} : 33'd0);
                e.r = u[31:0];
                e.c = u[32];
                s   = longint'($signed(x)) + longint'($signed(y)) + ((o == 4'd4) ? longint'(c) : 0);
                e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd3: begin
                e.r = x - y;
                e.c = (x >= y);
                s   = longint'($signed(x)) - longint'($signed(y));
                e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd5:  e.r = {31'd0, ($signed(x) < $signed(y))};
            4'd6:  e.r = {31'd0, (x < y)};
            4'd7:  e.r = ~(x | y);
            4'd8:  e.r = x ^ y;
            4'd9:  e.r = x << y[4:0];
            4'd10: e.r = x >> y[4:0];
            4'd11: e.r = 32'($signed(x) >>> y[4:0]);
            4'd12: begin
                p   = {32'd0, x} * {32'd0, y};
                e.r = p[31:0];
            end
            default: e.r = 32'd0;
        endcase
        e.z = (e.r == 32'd0);
        return e;
    endfunction

    // Drive a bundle, wait (bounded) for acceptance, queue its expectation.
    task automatic send(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic c, output int stalls);
        in_valid = 1'b1;
        op       = o;
        a        = x;
        b        = y;
        cin      = c;
        stalls   = 0;
        @(negedge clk);
        while (!in_ready && stalls < 200) begin
            @(negedge clk);
            stalls++;
        end
        if (!in_ready) check("accept_timeout", 64'd0, 64'd1);
        else sb.push_back(model(o, x, y, c));
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                n_out++;
                if (sb.size() == 0) begin
                    check("sb_unexpected", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("sb_result", 64'(result), 64'(e.r));
                    check("sb_cout", 64'(cout), 64'(e.c));
                    check("sb_zero", 64'(zero), 64'(e.z));
                    check("sb_ovf", 64'(ovf), 64'(e.v));
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int          st;
        int          lat;
        int          out_before;
        logic [31:0] held;
        logic [3:0]  ops [12];
        logic [31:0] as  [12];
        logic [31:0] bs  [12];
        logic        cs  [12];

        ops = '{4'd2, 4'd3, 4'd3, 4'd5, 4'd6, 4'd11, 4'd0, 4'd1, 4'd7, 4'd8, 4'd9, 4'd13};
        as  = '{32'h7FFF_FFFF, 32'd5, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000,
                32'hF0F0_1234, 32'h0F00_0001, 32'h1234_5678, 32'hAAAA_5555, 32'h0000_0003,
                32'h1234_5678};
        bs  = '{32'd1, 32'd5, 32'd5, 32'd1, 32'd1, 32'd4, 32'h0FF0_FFFF, 32'h00F0_0010,
                32'h0000_FFFF, 32'hFFFF_0000, 32'h0000_0021, 32'h9ABC_DEF0};
        cs  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset held two cycles with a pending bundle.
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        op        = 4'd2;
        a         = 32'd1;
        b         = 32'd2;
        cin       = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_flags", 64'({cout, zero, ovf}), 64'd0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Single ADD: 1-cycle latency, overflow into the sign bit.
        @(posedge clk);
        #1;
        send(4'd2, 32'h7FFF_FFFF, 32'd1, 1'b0, st);
        in_valid = 1'b0;
        @(negedge clk);
        check("add_lat_valid", 64'(out_valid), 64'd1);
        check("add_lat_result", 64'(result), 64'h8000_0000);
        check("add_lat_ovf", 64'(ovf), 64'd1);
        @(posedge clk);
        #1;

        // Directed op table, back to back.
        for (int i = 0; i < 12; i++) begin
            send(ops[i], as[i], bs[i], cs[i], st);
        end
        send(4'd4, 32'hFFFF_FFFF, 32'd0, 1'b1, st);
        send(4'd4, 32'h7FFF_FFFE, 32'd1, 1'b1, st);
        send(4'd3, 32'h0000_0001, 32'h8000_0000, 1'b0, st);
        send(4'd10, 32'h8000_0000, 32'd31, 1'b0, st);

        // Back-to-back ADDs with out_ready high: no stall cycles.
        for (int i = 0; i < 6; i++) begin
            send(4'd2, $urandom, $urandom, 1'b0, st);
            check("b2b_stall", 64'(st), 64'd0);
        end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Output back-pressure for 3 cycles.
        out_ready = 1'b0;
        send(4'd2, 32'd100, 32'd23, 1'b0, st);
        out_before = n_out;
        op       = 4'd8;
        a        = 32'h0000_00FF;
        b        = 32'h0000_0F0F;
        in_valid = 1'b1;
        held     = 32'd123;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_out_valid", 64'(out_valid), 64'd1);
            check("stall_result", 64'(result), 64'(held));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(4'd8, 32'h0000_00FF, 32'h0000_0F0F, 1'b0, st);
        check("stall_resume", 64'(st), 64'd0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("stall_count", 64'(n_out - out_before), 64'd2);

        // MUL latency and input stall.
        send(4'd12, 32'd1234, 32'd5678, 1'b0, st);
        in_valid = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!out_valid && lat < 100) begin
            check("mul_in_ready", 64'(in_ready), 64'd0);
            @(negedge clk);
            lat++;
        end
        check("mul_latency", 64'(lat), 64'd32);
        check("mul_result", 64'(result), 64'd7006652);
        @(posedge clk);
        #1;
        send(4'd12, 32'h0001_0000, 32'h0001_0000, 1'b0, st);
        send(4'd12, $urandom, $urandom, 1'b0, st);
        send(4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, st);
        send(4'd3, 32'd9, 32'd4, 1'b0, st);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset in the 10th cycle of a MUL: no output, aborted result dropped.
        send(4'd12, 32'd3, 32'd4, 1'b0, st);
        in_valid = 1'b0;
        void'(sb.pop_back());
        out_before = n_out;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("mulrst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) check("mulrst_no_output", 64'(out_valid), 64'd0);
        end
        check("mulrst_out_count", 64'(n_out - out_before), 64'd0);
        @(posedge clk);
        #1;
        send(4'd2, 32'd7, 32'd8, 1'b0, st);
        in_valid = 1'b0;
        @(negedge clk);
        check("mulrst_next_result", 64'(result), 64'd15);

        lat = 0;
        while (sb.size() != 0 && lat < 200) begin
            @(posedge clk);
            lat++;
        end
        @(negedge clk);
        check("sb_drain", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
